sdram_chip_model: RTL and testbench
===================================

// Module: sdram_chip_model
// PURPOSE
//  Synthesizable single-clock responder for the 16-bit MT48LC16M16 SDRAM pin interface.
//  Decodes the controller's SDRAM commands and stores data in an internal array.
//  Returns read data after the programmed CAS latency and flags protocol violations.
//  Replaces the external chip in Verilator/FPGA loopback benches of the SDRAM controller.
// PARAMETERS
//  MEM_AW   12  log2 of internal word array depth; stored index = {BA,row,col} truncated to MEM_AW LSBs
//  T_RCD    2   minimum clk cycles from ACTIVE to READ/WRITE on the same bank
//  T_RFC    6   minimum clk cycles from AUTO_REFRESH to the next non-NOP command
// PORTS
//  clk         in     1   core clock; same clock that drives the controller
//  rst_n       in     1   asynchronous active-low reset
//  SDRAM_DQ    inout  16  data bus; model drives it only while returning read data
//  SDRAM_A     in     13  address; row at ACTIVE, {DQMH,DQML,AP,col[9:0]} at READ/WRITE
//  SDRAM_BA    in     2   bank select
//  SDRAM_DQML  in     1   low-byte write mask; 1 = masked
//  SDRAM_DQMH  in     1   high-byte write mask; 1 = masked
//  SDRAM_nCS   in     1   chip select, active low; 1 = command treated as NOP
//  SDRAM_nRAS  in     1   command bit 2
//  SDRAM_nCAS  in     1   command bit 1
//  SDRAM_nWE   in     1   command bit 0
//  SDRAM_CKE   in     1   clock enable; 0 = command ignored and read pipeline frozen
//  ready       out    1   init complete (PRECHARGE-all, then LOAD_MODE seen)
//  refresh_cnt out    16  AUTO_REFRESH commands accepted since reset; wraps 0xFFFF->0
//  err         out    1   sticky protocol-error flag
//  err_code    out    3   code of first error; frozen once err=1
// BEHAVIOUR
//  - Reset: DQ hi-Z, ready=0, all banks closed, mode invalid, refresh_cnt=0, err=0, err_code=0.
//    The memory array is not reset.
//  - Command {nRAS,nCAS,nWE} is sampled at every posedge clk with nCS=0 and CKE=1.
//    Codes: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE,
//    001 AUTO_REFRESH, 000 LOAD_MODE, 110 BURST_TERMINATE (treated as NOP).
//  - Init FSM: UNINIT -(PRECHARGE with A10=1)-> PRECH -(LOAD_MODE)-> READY.
//    Only AUTO_REFRESH is also legal in UNINIT and PRECH.
//    LOAD_MODE latches CL=A[6:4] and BL=A[2:0]. ready=1 from the cycle after LOAD_MODE.
//    LOAD_MODE is legal again in READY when all banks are closed.
//  - Per-bank state: open flag, row[12:0], and an ACTIVE age counter saturating at T_RCD.
//    ACTIVE opens the bank. PRECHARGE closes BA, or all banks if A10=1.
//  - READ/WRITE: col=A[9:0]. If A10=1 (auto-precharge), the bank closes after the access.
//  - WRITE: DQ is sampled on the same edge as the command.
//    Byte [7:0] is written unless DQML=1; byte [15:8] is written unless DQMH=1.
//  - READ: command sampled at edge k. Data is driven on DQ from just after edge k+CL-1
//    until just after edge k+CL (one cycle), so a register capturing at edge k+CL sees it.
//  - Read pipeline: CL-deep shift register of {valid,data}. DQM on READ is ignored.
//    Back-to-back READs pipeline with no gaps.
//  - A WRITE landing in a cycle where read data is due cancels the drive
//    (bus turnaround) and raises error 6.
//  - AUTO_REFRESH: refresh_cnt+1. Next non-NOP command is allowed after T_RFC cycles.
//  - Simultaneous events: the array write and the read pipeline issue share one port.
//    Only one command per edge exists, so there is no port conflict.
//  - Mid-operation reset: in-flight read data is dropped, DQ goes hi-Z immediately
//    (async), and all state returns to its reset values.
// CONFIGURATION
//  SDRAM_MODEL_CHECK_EN defined: protocol checker active.
//    First violation sets err=1 and err_code. Codes:
//    1 access before ready; 2 ACTIVE to open bank; 3 READ/WRITE to closed bank;
//    4 tRCD violated; 5 REFRESH with a bank open or tRFC violated;
//    6 DQ turnaround clash; 7 unsupported mode (CL not 2 or 3, BL not 1).
//    Illegal commands are still executed best-effort.
//  Not defined: err and err_code are tied to 0. No checker logic is built.
//    Unsupported CL values behave as CL=2.
// TESTING
//  - Init: PRECHARGE A=0x0400, then LOAD_MODE A=0x0220 -> ready=1 next cycle, CL=2, err=0.
//  - Write/read: ACTIVE BA=1 row=0x0123; 2 cycles later WRITE col=0x005, AP=1, DQ=0xBEEF;
//    then ACTIVE, READ -> DQ=0xBEEF valid for the capture at edge k+2; bank closed after.
//  - Byte mask: preload 0x1234; WRITE 0xABCD with DQMH=1 -> subsequent read returns 0x12CD.
//  - CL=3: LOAD_MODE A=0x0230; READ -> data at edge k+3; DQ hi-Z at k+2 and at k+4.
//  - Errors (CHECK_EN): READ to closed bank -> err=1, code 3; a later ACTIVE-after-1-cycle
//    violation leaves code at 3. Without CHECK_EN, err stays 0.
//  - Refresh & reset: 3 AUTO_REFRESH spaced 8 cycles -> refresh_cnt=3;
//    assert rst_n=0 while a READ is in flight -> DQ hi-Z, ready=0, refresh_cnt=0.

Source files
------------

// File: rtl/sdram_chip_model_if.sv
// Command/address pins of a 16-bit MT48LC16M16 SDRAM, driven by the controller (master)
// into the chip model (slave). The DQ data bus is a separate inout port on the model.
interface sdram_chip_model_if;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic        SDRAM_CKE;

    modport master (
        output SDRAM_A, SDRAM_BA, SDRAM_DQML, SDRAM_DQMH,
               SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE
    );
    modport slave (
        input  SDRAM_A, SDRAM_BA, SDRAM_DQML, SDRAM_DQMH,
               SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE
    );
endinterface

// File: rtl/sdram_chip_model.sv
// Synthesizable MT48LC16M16 responder: command decode, word array, CL-delayed read data.
// Define SDRAM_MODEL_CHECK_EN to build the protocol checker (err/err_code); otherwise both are 0.
module sdram_chip_model #(
    parameter int MEM_AW = 12,
    parameter int T_RCD  = 2,
    parameter int T_RFC  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sdram_chip_model_if.slave        bus,
    inout  wire  [15:0]              SDRAM_DQ,
    output logic                     ready,
    output logic [15:0]              refresh_cnt,
    output logic                     err,
    output logic [2:0]               err_code
);
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {ST_UNINIT, ST_PRECH, ST_READY} init_e;

    typedef struct packed {
        logic        vld;
        logic [15:0] data;
    } rd_slot_t;

    localparam int AGE_W = $clog2(T_RCD + 1);
    localparam int RFC_W = $clog2(T_RFC + 1);
    localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(T_RCD);
    localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(T_RFC - 1);

    init_e                   state_q;
    logic                    ready_q;
    logic [3:0]              open_q;
    logic [3:0][12:0]        row_q;
    logic [3:0][AGE_W-1:0]   age_q;
    logic [RFC_W-1:0]        rfc_q;
    logic [2:0]              cl_q;
    rd_slot_t [2:0]          pipe_q;
    logic [15:0]             refresh_q;
    logic [15:0]             mem [2**MEM_AW];

    cmd_e              cmd;
    logic [1:0]        ba;
    logic              a10;
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]        rd_slot;
    logic              wr_clash;

    // nCS high or CKE low turns the edge into a NOP.
    assign cmd = (!bus.SDRAM_nCS && bus.SDRAM_CKE)
               ? cmd_e'({bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE}) : CMD_NOP;
    assign ba       = bus.SDRAM_BA;
    assign a10      = bus.SDRAM_A[10];
    assign mem_idx  = MEM_AW'({ba, row_q[ba], bus.SDRAM_A[9:0]});
    assign rd_slot  = (cl_q == 3'd3) ? 2'd2 : 2'd1;
    assign wr_clash = pipe_q[0].vld && (cmd == CMD_WR);

    // Read data owns the bus for one cycle unless a WRITE claims it in that same cycle.
    assign SDRAM_DQ    = (pipe_q[0].vld && !wr_clash) ? pipe_q[0].data : 16'hzzzz;
    assign ready       = ready_q;
    assign refresh_cnt = refresh_q;

    // NOTE: the storage array has no reset; clearing it would forbid RAM inference.
    always_ff @(posedge clk) begin
        if (cmd == CMD_WR) begin
            if (!bus.SDRAM_DQML) mem[mem_idx][7:0]  <= SDRAM_DQ[7:0];
            if (!bus.SDRAM_DQMH) mem[mem_idx][15:8] <= SDRAM_DQ[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UNINIT;
            ready_q   <= 1'b0;
            open_q    <= '0;
            row_q     <= '0;
            age_q     <= '0;
            rfc_q     <= '0;
            cl_q      <= 3'd2;
            pipe_q    <= '0;
            refresh_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (age_q[b] != AGE_SAT) age_q[b] <= age_q[b] + 1'b1;
            if (rfc_q != '0) rfc_q <= rfc_q - 1'b1;
            if (bus.SDRAM_CKE) pipe_q <= {rd_slot_t'('0), pipe_q[2:1]};

            case (cmd)
                CMD_ACT: begin
                    open_q[ba] <= 1'b1;
                    row_q[ba]  <= bus.SDRAM_A;
                    age_q[ba]  <= AGE_W'(1);
                end
                CMD_PRE: begin
                    if (a10) open_q <= '0;
                    else     open_q[ba] <= 1'b0;
                end
                CMD_RD: begin
                    pipe_q[rd_slot] <= {1'b1, mem[mem_idx]};
                    if (a10) open_q[ba] <= 1'b0;
                end
                CMD_WR: begin
                    if (a10) open_q[ba] <= 1'b0;
                end
                CMD_REF: begin
                    refresh_q <= refresh_q + 16'd1;
                    rfc_q     <= RFC_LOAD;
                end
                CMD_LMR: cl_q <= bus.SDRAM_A[6:4];
                default: ;
            endcase

            case (state_q)
                ST_UNINIT: if (cmd == CMD_PRE && a10) state_q <= ST_PRECH;
                ST_PRECH: if (cmd == CMD_LMR) begin
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SDRAM_MODEL_CHECK_EN
    logic       is_nop;
    logic       init_legal;
    logic       mode_bad;
    logic [2:0] viol;
    logic       err_q;
    logic [2:0] err_code_q;

    assign is_nop     = (cmd == CMD_NOP) || (cmd == CMD_BST);
    assign init_legal = (cmd == CMD_REF)
                     || (state_q == ST_UNINIT && cmd == CMD_PRE && a10)
                     || (state_q == ST_PRECH  && cmd == CMD_LMR);
    assign mode_bad   = !(bus.SDRAM_A[6:4] == 3'd2 || bus.SDRAM_A[6:4] == 3'd3)
                     || (bus.SDRAM_A[2:0] != 3'd0);

    // NOTE: viol gets a default before any branch so this block cannot infer a latch.
    always_comb begin
        viol = 3'd0;
        if (!is_nop && rfc_q != '0) begin
            viol = 3'd5;
        end else if (!is_nop && state_q != ST_READY && !init_legal) begin
            viol = 3'd1;
        end else begin
            case (cmd)
                CMD_ACT: if (open_q[ba]) viol = 3'd2;
                CMD_RD, CMD_WR: begin
                    if (!open_q[ba])                viol = 3'd3;
                    else if (age_q[ba] < AGE_SAT)   viol = 3'd4;
                end
                CMD_REF: if (|open_q) viol = 3'd5;
                CMD_LMR: if (mode_bad) viol = 3'd7;
                default: ;
            endcase
        end
        if (viol == 3'd0 && wr_clash) viol = 3'd6;
    end

    // Only the first violation is recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else if (!err_q && viol != 3'd0) begin
            err_q      <= 1'b1;
            err_code_q <= viol;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_chip_model.sv
// Self-checking bench for sdram_chip_model: table-driven masked write/read vectors with a
// read-data scoreboard, plus hand sequences for init, CL=3, errors, refresh and reset.
module tb_sdram_chip_model;
    localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;
`ifdef SDRAM_MODEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_chip_model_if bus();
    wire  [15:0] dq_bus;
    logic [15:0] tb_dq    = 16'h0;
    logic        tb_dq_en = 1'b0;
    assign dq_bus = tb_dq_en ? tb_dq : 16'hzzzz;

    logic        ready;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    sdram_chip_model dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .SDRAM_DQ    (dq_bus),
        .ready       (ready),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    int n_vec = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int cl_cur = 2;

    typedef struct {
        int          due;
        logic [15:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [9:0]  col;
        logic [15:0] pre;
        logic [15:0] wd;
        logic        ml;
        logic        mh;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // An undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
    task automatic check_hiz(input string name);
        n_vec++;
        if (!($isunknown(dq_bus) || dq_bus == 16'h0)) begin
            n_bad++;
            $display("FAIL %s: DQ driven with 0x%0h, expected hi-Z", name, dq_bus);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Read data is sampled mid-cycle, ahead of the capture edge k+CL.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= edge_cnt) begin
            if (sb[0].due == edge_cnt) begin
                check(sb[0].name, dq_bus, sb[0].exp);
            end else begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: read slot missed", sb[0].name);
            end
            void'(sb.pop_front());
        end
    end

    task automatic cyc(input logic [2:0] c, input logic [1:0] ba = 2'd0,
                       input logic [12:0] a = 13'd0, input logic ml = 1'b0,
                       input logic mh = 1'b0, input logic wen = 1'b0,
                       input logic [15:0] wd = 16'h0);
        // NOTE: stimulus uses blocking assignments, applied 1ns after the edge it follows.
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
        bus.SDRAM_BA   = ba;
        bus.SDRAM_A    = a;
        bus.SDRAM_DQML = ml;
        bus.SDRAM_DQMH = mh;
        tb_dq_en       = wen;
        tb_dq          = wd;
        @(posedge clk);
        #1;
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;
        tb_dq_en = 1'b0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(C_NOP);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [9:0] col, input logic [15:0] d,
                      input logic ml, input logic mh, input logic ap);
        cyc(C_WR, ba, {mh, ml, ap, col}, ml, mh, 1'b1, d);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [9:0] col, input logic ap,
                      input bit push, input logic [15:0] exp, input string name);
        cyc(C_RD, ba, {2'b00, ap, col});
        if (push) sb.push_back('{edge_cnt + cl_cur - 1, exp, name});
    endtask

    task automatic init_seq();
        cyc(C_PRE, 2'd0, 13'h0400);
        check("prech_not_ready", ready, 0);
        cyc(C_LMR, 2'd0, 13'h0220);
        cl_cur = 2;
        check("init_ready", ready, 1);
        check("init_err", err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{10'h010, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
        vt[1] = '{10'h011, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h00FF};
        vt[2] = '{10'h012, 16'h5555, 16'hAAAA, 1'b0, 1'b1, 16'h55AA};
        vt[3] = '{10'h013, 16'h1357, 16'h2468, 1'b1, 1'b1, 16'h1357};
        vt[4] = '{10'h3FF, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 16'h7FFE};
        vt[5] = '{10'h000, 16'hC3C3, 16'h3C3C, 1'b1, 1'b0, 16'h3CC3};

        bus.SDRAM_nCS  = 1'b0;
        bus.SDRAM_CKE  = 1'b1;
        bus.SDRAM_BA   = 2'd0;
        bus.SDRAM_A    = 13'd0;
        bus.SDRAM_DQML = 1'b0;
        bus.SDRAM_DQMH = 1'b0;
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_refresh", refresh_cnt, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check_hiz("rst_dq");
        rst_n = 1'b1;
        nops(2);

        init_seq();

        // Write with auto-precharge, reopen, read back.
        cyc(C_ACT, 2'd1, 13'h0123);
        nops(1);
        wr(2'd1, 10'h005, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        cyc(C_ACT, 2'd1, 13'h0123);
        nops(1);
        rd(2'd1, 10'h005, 1'b1, 1'b1, 16'hBEEF, "rd_beef");
        nops(3);
        check_hiz("rd_release");
        cyc(C_ACT, 2'd1, 13'h0123);
        nops(1);
        check("ap_closed_err", err, 0);
        cyc(C_PRE, 2'd1, 13'h0000);

        // High byte masked.
        cyc(C_ACT, 2'd0, 13'h0010);
        nops(1);
        wr(2'd0, 10'h007, 16'h1234, 1'b0, 1'b0, 1'b0);
        wr(2'd0, 10'h007, 16'hABCD, 1'b0, 1'b1, 1'b0);
        rd(2'd0, 10'h007, 1'b1, 1'b1, 16'h12CD, "rd_mask");
        nops(2);

        // Table vectors: preload, masked write, then back-to-back reads.
        cyc(C_ACT, 2'd2, 13'h0055);
        nops(1);
        for (int i = 0; i < 6; i++) wr(2'd2, vt[i].col, vt[i].pre, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) wr(2'd2, vt[i].col, vt[i].wd, vt[i].ml, vt[i].mh, 1'b0);
        for (int i = 0; i < 6; i++) rd(2'd2, vt[i].col, 1'b0, 1'b1, vt[i].exp, $sformatf("vec%0d", i));
        nops(3);
        cyc(C_PRE, 2'd2, 13'h0000);
        check("vec_err", err, 0);

        // CL=3: bus idle at captures k+2 and k+4, data at k+3.
        cyc(C_PRE, 2'd0, 13'h0400);
        cyc(C_LMR, 2'd0, 13'h0230);
        cl_cur = 3;
        cyc(C_ACT, 2'd1, 13'h0123);
        nops(1);
        rd(2'd1, 10'h005, 1'b1, 1'b1, 16'hBEEF, "cl3_data");
        nops(1);
        @(negedge clk);
        check_hiz("cl3_hiz_k2");
        nops(2);
        @(negedge clk);
        check_hiz("cl3_hiz_k4");
        check("cl3_err", err, 0);

        // READ to closed bank, then a tRCD violation that must not overwrite the code.
        rd(2'd3, 10'h001, 1'b0, 1'b0, 16'h0, "");
        check("err_closed", err, CHK);
        check("code_closed", err_code, CHK ? 3 : 0);
        cyc(C_ACT, 2'd3, 13'h0001);
        rd(2'd3, 10'h001, 1'b0, 1'b0, 16'h0, "");
        nops(4);
        check("err_sticky", err, CHK);
        check("code_sticky", err_code, CHK ? 3 : 0);

        // Reset between tests.
        rst_n = 1'b0;
        #3;
        check("rst2_err", err, 0);
        check("rst2_ready", ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nops(2);
        init_seq();

        // Refresh spacing; CKE-low and deselected refreshes are ignored; ACT at exactly tRFC.
        cyc(C_REF);
        nops(7);
        cyc(C_REF);
        nops(7);
        cyc(C_REF);
        bus.SDRAM_CKE = 1'b0;
        cyc(C_REF);
        bus.SDRAM_CKE = 1'b1;
        bus.SDRAM_nCS = 1'b1;
        cyc(C_REF);
        bus.SDRAM_nCS = 1'b0;
        nops(3);
        cyc(C_ACT, 2'd0, 13'h0000);
        check("refresh_cnt", refresh_cnt, 3);
        check("refresh_err", err, 0);

        // WRITE in the cycle read data is due: bus belongs to the writer.
        nops(2);
        rd(2'd0, 10'h007, 1'b0, 1'b0, 16'h0, "");
        nops(1);
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_WR;
        bus.SDRAM_BA   = 2'd0;
        bus.SDRAM_A    = 13'h0007;
        bus.SDRAM_DQML = 1'b0;
        bus.SDRAM_DQMH = 1'b0;
        tb_dq          = 16'h5A5A;
        tb_dq_en       = 1'b1;
        @(negedge clk);
        check("clash_bus", dq_bus, 16'h5A5A);
        @(posedge clk);
        #1;
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;
        tb_dq_en = 1'b0;
        check("clash_err", err, CHK);
        check("clash_code", err_code, CHK ? 6 : 0);
        rd(2'd0, 10'h007, 1'b0, 1'b1, 16'h5A5A, "clash_wr_data");
        nops(3);

        // Reset while read data is on the bus.
        rd(2'd0, 10'h007, 1'b0, 1'b0, 16'h0, "");
        nops(1);
        check("inflight_drive", dq_bus, 16'h5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check_hiz("midrst_dq");
        check("midrst_ready", ready, 0);
        check("midrst_refresh", refresh_cnt, 0);
        check("midrst_err", err, 0);
        check("midrst_code", err_code, 0);
        repeat (2) @(posedge clk);
        #1;
        check_hiz("midrst_dq_hold");
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
